// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo -- UART receiver with 16x oversampling and a character FIFO.
//
// Receives asynchronous serial frames on rx. The frame format is set at runtime:
// 5-8 data bits, none/even/odd parity, and 1 or 2 stop bits. The baud divisor is
// also runtime-programmable. Each character is stored in a DEPTH-entry
// first-word-fall-through FIFO together with its frame and parity error flags.
//
// Optional feature: define UART_RX_BREAK_DET_EN to build the line-break detector.
// Without it, break_det is tied to 0.
//
// Ports
//   clk            system clock
//   rst            synchronous, active-high reset
//   rx             serial input (asynchronous, idle high)
//   cfg_baud_div   one oversample tick every cfg_baud_div+1 clocks
//   cfg_data_bits  00=5 01=6 10=7 11=8 data bits
//   cfg_parity     00/11=none 01=even 10=odd
//   cfg_stop2      0=1 stop bit, 1=2 stop bits
//   rd_en          pop the head entry
//   clear_err      clear overrun_err
//   rd_data        head data, LSB-aligned, unused MSBs zero (0 while empty)
//   rd_frame_err   head entry had a stop bit sampled low
//   rd_parity_err  head entry had a parity mismatch
//   empty, full    FIFO status
//   count          number of entries held
//   overrun_err    sticky: a character was dropped because the FIFO was full
//   break_det      break seen; held until rx returns high
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int DIV_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  input  logic [DIV_W-1:0]       cfg_baud_div,
  input  logic [1:0]             cfg_data_bits,
  input  logic [1:0]             cfg_parity,
  input  logic                   cfg_stop2,
  input  logic                   rd_en,
  input  logic                   clear_err,
  output logic [7:0]             rd_data,
  output logic                   rd_frame_err,
  output logic                   rd_parity_err,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overrun_err,
  output logic                   break_det
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, PUSH} state_t;
  state_t state_reg, state_next;

  // Two-stage synchroniser. rx_prev_reg is used to detect the falling edge of a start bit.
  logic [1:0] sync_reg;
  logic       rx_prev_reg;
  logic       rx_s, fall;
  assign rx_s = sync_reg[1];
  assign fall = rx_prev_reg & ~rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg    <= 2'b11;
      rx_prev_reg <= 1'b1;
    end else begin
      sync_reg    <= {sync_reg[0], rx};
      rx_prev_reg <= rx_s;
    end
  end

  // Frame-latched configuration and receive datapath
  logic [DIV_W-1:0] div_reg, div_cnt_reg;
  logic [3:0]       os_cnt_reg;
  logic [2:0]       bit_cnt_reg, last_bit_reg;
  logic [1:0]       par_mode_reg;
  logic             stop2_reg;
  logic [7:0]       shift_reg;
  logic             par_acc_reg, perr_reg, ferr_reg;
  logic             tick, mid, par_en, push;
  logic [7:0]       data_aligned;

  assign tick   = (div_cnt_reg == div_reg);
  assign mid    = tick && (os_cnt_reg == 4'd7);
  assign par_en = (par_mode_reg == 2'b01) || (par_mode_reg == 2'b10);
  // Bits enter at the MSB, so a short character ends up left-justified.
  // Shift it down to the LSB.
  assign data_aligned = shift_reg >> (3'd7 - last_bit_reg);

  always_comb begin
    state_next = state_reg;
    push       = 1'b0;
    case (state_reg)
      IDLE:    if (fall) state_next = START;
      START:   if (mid) state_next = rx_s ? IDLE : DATA;
      DATA:    if (mid && bit_cnt_reg == last_bit_reg) state_next = par_en ? PARITY : STOP1;
      PARITY:  if (mid) state_next = STOP1;
      STOP1:   if (mid) state_next = stop2_reg ? STOP2 : PUSH;
      STOP2:   if (mid) state_next = PUSH;
      PUSH: begin
        push       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg      <= '0;
      div_cnt_reg  <= '0;
      os_cnt_reg   <= '0;
      bit_cnt_reg  <= '0;
      last_bit_reg <= 3'd7;
      par_mode_reg <= '0;
      stop2_reg    <= 1'b0;
      shift_reg    <= '0;
      par_acc_reg  <= 1'b0;
      perr_reg     <= 1'b0;
      ferr_reg     <= 1'b0;
    end else begin
      // The oversample counters run only inside a frame.
      // They sit at zero so a new start edge always begins a fresh bit.
      if (state_reg == IDLE || state_reg == PUSH) begin
        div_cnt_reg <= '0;
        os_cnt_reg  <= '0;
      end else if (tick) begin
        div_cnt_reg <= '0;
        os_cnt_reg  <= os_cnt_reg + 4'd1;
      end else begin
        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
      end

      case (state_reg)
        IDLE: if (fall) begin
          div_reg      <= cfg_baud_div;
          last_bit_reg <= {1'b1, cfg_data_bits};
          par_mode_reg <= cfg_parity;
          stop2_reg    <= cfg_stop2;
          bit_cnt_reg  <= '0;
          shift_reg    <= '0;
          par_acc_reg  <= 1'b0;
          perr_reg     <= 1'b0;
          ferr_reg     <= 1'b0;
        end
        DATA: if (mid) begin
          shift_reg   <= {rx_s, shift_reg[7:1]};
          par_acc_reg <= par_acc_reg ^ rx_s;
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
        end
        PARITY: if (mid) perr_reg <= ((par_acc_reg ^ rx_s) != (par_mode_reg == 2'b10));
        STOP1, STOP2: if (mid && !rx_s) ferr_reg <= 1'b1;
        default: ;
      endcase
    end
  end

  // FWFT FIFO. The read is asynchronous so the head entry is visible without a pop.
  logic [9:0]  mem [DEPTH];
  logic [9:0]  head;
  logic [AW:0] wr_cnt_reg, rd_cnt_reg;
  logic        do_push, do_pop, overrun_reg;

  assign count   = wr_cnt_reg - rd_cnt_reg;
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = rd_en && !empty;
  // When the FIFO is full, a push is accepted only if a pop frees a slot in the same cycle.
  assign do_push = push && (!full || rd_en);
  assign head    = mem[rd_cnt_reg[AW-1:0]];

  assign rd_data       = empty ? 8'h00 : head[7:0];
  assign rd_parity_err = empty ? 1'b0  : head[8];
  assign rd_frame_err  = empty ? 1'b0  : head[9];
  assign overrun_err   = overrun_reg;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_cnt_reg[AW-1:0]] <= {ferr_reg, perr_reg, data_aligned};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_reg  <= '0;
      rd_cnt_reg  <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (do_push) wr_cnt_reg <= wr_cnt_reg + (AW+1)'(1);
      if (do_pop)  rd_cnt_reg <= rd_cnt_reg + (AW+1)'(1);
      if (push && full && !rd_en) overrun_reg <= 1'b1;
      else if (clear_err)         overrun_reg <= 1'b0;
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  // A break frame is a start bit, then all-zero data and parity, then a low first stop bit.
  logic ones_reg, brk_reg, break_reg;
  always_ff @(posedge clk) begin
    if (rst) begin
      ones_reg  <= 1'b0;
      brk_reg   <= 1'b0;
      break_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE && fall) begin
        ones_reg <= 1'b0;
        brk_reg  <= 1'b0;
      end else if ((state_reg == DATA || state_reg == PARITY) && mid && rx_s) begin
        ones_reg <= 1'b1;
      end else if (state_reg == STOP1 && mid) begin
        brk_reg <= !ones_reg && !rx_s;
      end
      if (push && brk_reg) break_reg <= 1'b1;
      else if (rx_s)       break_reg <= 1'b0;
    end
  end
  assign break_det = break_reg;
`else
  assign break_det = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst, rx, cfg_stop2, rd_en, clear_err;
  logic [DIV_W-1:0] cfg_baud_div;
  logic [1:0]       cfg_data_bits, cfg_parity;
  logic [7:0]       rd_data;
  logic             rd_frame_err, rd_parity_err, empty, full, overrun_err, break_det;
  logic [4:0]       count;

  uart_rx_fifo #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .rx(rx), .cfg_baud_div(cfg_baud_div),
    .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .rd_en(rd_en), .clear_err(clear_err), .rd_data(rd_data),
    .rd_frame_err(rd_frame_err), .rd_parity_err(rd_parity_err), .empty(empty),
    .full(full), .count(count), .overrun_err(overrun_err), .break_det(break_det)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Current line configuration, as the transmitter in this bench sees it
  int         cur_div, cur_bits, bit_clks;
  logic [1:0] cur_par;
  bit         cur_stop2;

  // Per-frame bookkeeping used by the serial driver
  int         cyc_in_frame, seen_at, seen_count;
  int         pulse_at = -1;
  bit         hold_rd  = 1'b0;
  logic [7:0] seen_data;

  logic [9:0] q[$];   // expected FIFO contents {frame_err, parity_err, data}

`ifdef UART_RX_BREAK_DET_EN
  localparam logic EXP_BRK = 1'b1;
`else
  localparam logic EXP_BRK = 1'b0;
`endif

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic set_cfg(input int div, input int nbits, input logic [1:0] par, input bit s2);
    cur_div   = div;
    cur_bits  = nbits;
    cur_par   = par;
    cur_stop2 = s2;
    bit_clks  = 16 * (div + 1);
    cfg_baud_div  = DIV_W'(div);
    cfg_data_bits = 2'(nbits - 5);
    cfg_parity    = par;
    cfg_stop2     = s2;
  endtask

  function automatic logic [7:0] masked(input logic [7:0] d);
    return d & 8'((1 << cur_bits) - 1);
  endfunction

  // Parity bit the transmitter puts on the wire. flip makes it deliberately wrong.
  function automatic logic par_bit(input logic [7:0] d, input bit flip);
    int ones;
    ones = $countones(masked(d));
    if (cur_par == 2'b01) return 1'((ones % 2) ^ int'(flip));
    return 1'(((ones + 1) % 2) ^ int'(flip));
  endfunction

  // Reference entry, derived from the frame rules
  function automatic logic [9:0] expect_entry(input logic [7:0] d, input bit flip,
                                              input bit s1, input bit s2);
    int   ones;
    logic perr, ferr;
    ones = $countones(masked(d)) + int'(par_bit(d, flip));
    perr = (cur_par == 2'b01 && (ones % 2) != 0) || (cur_par == 2'b10 && (ones % 2) != 1);
    ferr = !s1 || (cur_stop2 && !s2);
    return {ferr, perr, masked(d)};
  endfunction

  task automatic drive_bit(input logic b);
    rx = b;
    for (int i = 0; i < bit_clks; i++) begin
      @(negedge clk);
      cyc_in_frame++;
      rd_en = hold_rd || (cyc_in_frame == pulse_at);
      if (seen_at < 0 && !empty) begin
        seen_at    = cyc_in_frame;
        seen_data  = rd_data;
        seen_count = int'(count);
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit flip, input bit s1, input bit s2,
                            input int idle, input bit scramble);
    cyc_in_frame = 0;
    seen_at      = -1;
    drive_bit(1'b0);
    if (scramble) begin
      cfg_baud_div  = DIV_W'($urandom_range(0, 7));
      cfg_data_bits = 2'($urandom);
      cfg_parity    = 2'($urandom);
      cfg_stop2     = 1'($urandom);
    end
    for (int i = 0; i < cur_bits; i++) drive_bit(d[i]);
    if (cur_par == 2'b01 || cur_par == 2'b10) drive_bit(par_bit(d, flip));
    drive_bit(1'(s1));
    if (cur_stop2) drive_bit(1'(s2));
    set_cfg(cur_div, cur_bits, cur_par, cur_stop2);
    for (int i = 0; i < idle; i++) drive_bit(1'b1);
    rx = 1'b1;
  endtask

  task automatic pop_entry(output logic [9:0] got);
    got   = {rd_frame_err, rd_parity_err, rd_data};
    $display("pop data=%02h frame_err=%0b parity_err=%0b", got[7:0], got[9], got[8]);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; rx = 1'b1; rd_en = 1'b0; clear_err = 1'b0;
    set_cfg(3, 8, 2'b00, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b exp=0", full); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (overrun_err !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%0b exp=0", overrun_err); end
    total++; if (break_det !== 1'b0) begin bad++; $display("FAIL reset_break got=%0b exp=0", break_det); end
    total++; if ({rd_frame_err, rd_parity_err, rd_data} !== 10'h000) begin
      bad++; $display("FAIL reset_rd got=%03h exp=000", {rd_frame_err, rd_parity_err, rd_data});
    end
  endtask

  task automatic test_8n1;
    logic [9:0] got;
    set_cfg(3, 8, 2'b00, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1, 1'b0);
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL t1_empty got=%0b exp=0", empty); end
    total++; if (count !== 5'd1) begin bad++; $display("FAIL t1_count got=%0d exp=1", count); end
    pop_entry(got);
    total++; if (got !== 10'h0A5) begin bad++; $display("FAIL t1_entry got=%03h exp=0a5", got); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL t1_empty_after_pop got=%0b exp=1", empty); end
  endtask

  task automatic test_7e1;
    logic [9:0] got;
    set_cfg(2, 7, 2'b01, 1'b0);
    send_frame(8'h41, 1'b0, 1'b1, 1'b1, 1, 1'b0);
    send_frame(8'h41, 1'b1, 1'b1, 1'b1, 1, 1'b0);
    total++; if (count !== 5'd2) begin bad++; $display("FAIL t2_count got=%0d exp=2", count); end
    pop_entry(got);
    total++; if (got !== 10'h041) begin bad++; $display("FAIL t2_good_parity got=%03h exp=041", got); end
    pop_entry(got);
    total++; if (got !== 10'h141) begin bad++; $display("FAIL t2_bad_parity got=%03h exp=141", got); end
  endtask

  task automatic test_5o2;
    logic [9:0] got;
    set_cfg(2, 5, 2'b10, 1'b1);
    send_frame(8'hF5, 1'b0, 1'b1, 1'b0, 1, 1'b0);
    pop_entry(got);
    total++; if (got !== 10'h215) begin bad++; $display("FAIL t3_stop2_err got=%03h exp=215", got); end
  endtask

  task automatic test_push_pop_empty;
    logic [7:0] d;
    set_cfg(0, 8, 2'b00, 1'b0);
    d = 8'($urandom);
    hold_rd = 1'b1;
    send_frame(d, 1'b0, 1'b1, 1'b1, 1, 1'b0);
    hold_rd = 1'b0;
    rd_en   = 1'b0;
    total++; if (seen_at < 0) begin bad++; $display("FAIL pp_empty_no_push got=none exp=entry"); end
    total++; if (seen_count !== 1 || seen_data !== d) begin
      bad++; $display("FAIL pp_empty_entry got=%0d/%02h exp=1/%02h", seen_count, seen_data, d);
    end
    total++; if (empty !== 1'b1 || count !== 5'd0) begin
      bad++; $display("FAIL pp_empty_drained got=%0b/%0d exp=1/0", empty, count);
    end
  endtask

  task automatic test_overrun;
    logic [9:0] got, exp;
    logic [7:0] d;
    int         lat;
    set_cfg(1, 8, 2'b00, 1'b0);
    q.delete();
    for (int n = 0; n < 16; n++) begin
      d = 8'($urandom);
      send_frame(d, 1'b0, 1'b1, 1'b1, 1, 1'b0);
      if (n == 0) lat = seen_at;
      q.push_back(expect_entry(d, 1'b0, 1'b1, 1'b1));
    end
    total++; if (lat < 2) begin bad++; $display("FAIL ovr_first_push got=%0d exp=latency>1", lat); end
    total++; if (full !== 1'b1 || count !== 5'd16 || overrun_err !== 1'b0) begin
      bad++; $display("FAIL ovr_fill got=%0b/%0d/%0b exp=1/16/0", full, count, overrun_err);
    end
    // Frame 17: a pop lands in the push cycle, so the push is accepted and nothing is lost.
    d = 8'($urandom);
    pulse_at = lat - 1;
    send_frame(d, 1'b0, 1'b1, 1'b1, 1, 1'b0);
    pulse_at = -1;
    rd_en = 1'b0;
    void'(q.pop_front());
    q.push_back(expect_entry(d, 1'b0, 1'b1, 1'b1));
    total++; if (count !== 5'd16 || overrun_err !== 1'b0) begin
      bad++; $display("FAIL ovr_push_pop_full got=%0d/%0b exp=16/0", count, overrun_err);
    end
    total++; if ({rd_frame_err, rd_parity_err, rd_data} !== q[0]) begin
      bad++; $display("FAIL ovr_head_after_pop got=%03h exp=%03h", {rd_frame_err, rd_parity_err, rd_data}, q[0]);
    end
    // Frame 18: no pop, so this character is dropped.
    send_frame(8'($urandom), 1'b0, 1'b1, 1'b1, 1, 1'b0);
    total++; if (full !== 1'b1 || count !== 5'd16 || overrun_err !== 1'b1) begin
      bad++; $display("FAIL ovr_drop got=%0b/%0d/%0b exp=1/16/1", full, count, overrun_err);
    end
    for (int n = 0; n < 16; n++) begin
      exp = q.pop_front();
      pop_entry(got);
      total++; if (got !== exp) begin bad++; $display("FAIL ovr_order[%0d] got=%03h exp=%03h", n, got, exp); end
    end
    total++; if (empty !== 1'b1 || overrun_err !== 1'b1) begin
      bad++; $display("FAIL ovr_sticky got=%0b/%0b exp=1/1", empty, overrun_err);
    end
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    total++; if (overrun_err !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%0b exp=0", overrun_err); end
  endtask

  task automatic test_glitch_rst;
    logic [9:0] got;
    set_cfg(3, 8, 2'b00, 1'b0);
    rx = 1'b0;
    repeat (bit_clks / 2) @(negedge clk);
    rx = 1'b1;
    repeat (2 * bit_clks) @(negedge clk);
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL glitch_push got=%0d exp=0", count); end
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1, 1'b0);
    total++; if (count !== 5'd1 || {rd_frame_err, rd_parity_err, rd_data} !== 10'h03C) begin
      bad++; $display("FAIL glitch_next got=%0d/%03h exp=1/03c", count, {rd_frame_err, rd_parity_err, rd_data});
    end
    // Abort a frame part-way through its data bits.
    cyc_in_frame = 0;
    drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    total++; if (empty !== 1'b1 || count !== 5'd0) begin
      bad++; $display("FAIL rst_mid_frame got=%0b/%0d exp=1/0", empty, count);
    end
    repeat (12 * bit_clks) @(negedge clk);
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL rst_phantom got=%0d exp=0", count); end
    send_frame(8'hC3, 1'b0, 1'b1, 1'b1, 1, 1'b0);
    pop_entry(got);
    total++; if (got !== 10'h0C3) begin bad++; $display("FAIL rst_recover got=%03h exp=0c3", got); end
  endtask

  task automatic test_back_to_back;
    logic [9:0] got, exp;
    logic [7:0] d;
    bit         flip, s1, s2, last;
    int         idle;
    q.delete();
    for (int n = 0; n < 30; n++) begin
      set_cfg($urandom_range(0, 3), $urandom_range(5, 8), 2'($urandom), 1'($urandom));
      d    = 8'($urandom);
      flip = ($urandom_range(0, 3) == 0);
      s1   = ($urandom_range(0, 5) != 0);
      s2   = ($urandom_range(0, 5) != 0);
      last = cur_stop2 ? s2 : s1;
      idle = last ? $urandom_range(0, 1) : 1;
      q.push_back(expect_entry(d, flip, s1, s2));
      send_frame(d, flip, s1, s2, idle, 1'b1);
      if (q.size() >= 10 || n == 29) begin
        while (q.size() > 0) begin
          total++; if (int'(count) !== q.size()) begin
            bad++; $display("FAIL b2b_count got=%0d exp=%0d", count, q.size());
          end
          exp = q.pop_front();
          pop_entry(got);
          total++; if (got !== exp) begin bad++; $display("FAIL b2b_entry got=%03h exp=%03h", got, exp); end
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%0b exp=1", empty); end
      end
    end
  endtask

  task automatic test_break;
    logic [9:0] got;
    set_cfg(1, 8, 2'b00, 1'b0);
    rx = 1'b0;
    repeat (11 * bit_clks) @(negedge clk);
    total++; if (break_det !== EXP_BRK) begin bad++; $display("FAIL brk_set got=%0b exp=%0b", break_det, EXP_BRK); end
    total++; if (count !== 5'd1) begin bad++; $display("FAIL brk_count got=%0d exp=1", count); end
    repeat (bit_clks) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (break_det !== 1'b0) begin bad++; $display("FAIL brk_clear got=%0b exp=0", break_det); end
    pop_entry(got);
    total++; if (got !== 10'h200) begin bad++; $display("FAIL brk_entry got=%03h exp=200", got); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL brk_single got=%0d exp=0", count); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_7e1();
    test_5o2();
    test_push_pop_empty();
    test_overrun();
    test_glitch_rst();
    test_back_to_back();
    test_break();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
